// File: rtl/rangebin_zeropad_buffer.sv
// Range-bin capture buffer: windows a multi-lane sample stream into RAM and
// replays it as NFFT-sample frames (L buffered samples, then zero padding).
module rangebin_zeropad_buffer #(
  parameter int unsigned BIT_WIDTH = 14,
  parameter int unsigned LANES     = 2,
  parameter int unsigned NFFT      = 1024,
  parameter int unsigned DEPTH     = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BIT_WIDTH*LANES-1:0]   data_in,
  input  logic                         start,
  input  logic [15:0]                  nPointsPerBin,
  input  logic [15:0]                  Mirror_Position,
  input  logic [15:0]                  End_Position,
  input  logic                         out_ready,
  output logic [BIT_WIDTH-1:0]         data_out,
  output logic                         data_valid,
  output logic                         sof,
  output logic                         eof,
  output logic [7:0]                   bin_index,
  output logic                         busy,
  output logic                         overflow
);

  localparam int unsigned WORDS = DEPTH / LANES;
  localparam int unsigned AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned LSW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned FW    = $clog2(NFFT) + 1;
  localparam logic [FW-1:0] NFFT_F = FW'(NFFT);
  localparam logic [FW-1:0] LAST_F = FW'(NFFT - 1);

  typedef enum logic [1:0] {W_IDLE, W_SKIP, W_CAPTURE} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAITBIN, R_DATA, R_PAD} rd_state_t;

  wr_state_t wr_state;
  rd_state_t rd_state;

  logic [15:0]   word_cnt;
  logic [15:0]   mir_q;
  logic [15:0]   end_q;
  logic [FW-1:0] len_q;
  logic [AW:0]   wr_ptr;

  logic [BIT_WIDTH*LANES-1:0] mem [WORDS];
  logic [BIT_WIDTH*LANES-1:0] ram_q;

  logic [31:0]   rd_samp;
  logic [FW-1:0] frame_cnt;
  logic [7:0]    bin_q;

  logic                 valid_b;
  logic                 pad_b;
  logic                 sof_b;
  logic                 eof_b;
  logic [LSW-1:0]       lane_b;
  logic [7:0]           bin_b;

  logic                 accept;
  logic                 last_word;
  logic                 cap_word;
  logic                 room;
  logic                 we;
  logic [FW-1:0]        len_in;
  logic [FW-1:0]        len_m1;
  logic [31:0]          written;
  logic [31:0]          written_nxt;
  logic [31:0]          need;
  logic                 advance_c;
  logic                 ready_b;
  logic                 issue;
  logic                 re;
  logic [AW-1:0]        rd_addr;
  logic [LSW-1:0]       lane_nxt;
  logic [BIT_WIDTH-1:0] lane_word;

  assign busy   = (wr_state != W_IDLE) || (rd_state != R_IDLE) || valid_b || data_valid;
  assign accept = start && !busy;

  always_comb begin
    len_in    = (32'(nPointsPerBin) > NFFT) ? NFFT_F : FW'(nPointsPerBin);
    len_m1    = len_q - FW'(1);
    last_word = ({1'b0, word_cnt} + 17'd1) >= {1'b0, end_q};
    unique case (wr_state)
      W_SKIP:    cap_word = (mir_q < end_q) && (word_cnt == mir_q);
      W_CAPTURE: cap_word = 1'b1;
      default:   cap_word = 1'b0;
    endcase
    room = wr_ptr < (AW+1)'(WORDS);
    we   = cap_word && room;
  end

  // Bin readiness counts the word being written this cycle so the first read
  // can issue on the very next cycle, once the RAM already holds it.
  always_comb begin
    written     = 32'(wr_ptr) * 32'(LANES);
    written_nxt = written + (we ? 32'(LANES) : 32'd0);
    need        = rd_samp + 32'(len_q);
    advance_c   = !data_valid || out_ready;
    ready_b     = !valid_b || advance_c;
    issue       = ((rd_state == R_DATA) || (rd_state == R_PAD)) && ready_b;
    re          = issue && (rd_state == R_DATA);
    rd_addr     = AW'(rd_samp / 32'(LANES));
    lane_nxt    = LSW'(rd_samp % 32'(LANES));
  end

  always_comb begin
    lane_word = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (LSW'(i) == lane_b) lane_word = ram_q[i*BIT_WIDTH +: BIT_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr[AW-1:0]] <= data_in;
    if (re) ram_q <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state <= W_IDLE;
      word_cnt <= '0;
      mir_q    <= '0;
      end_q    <= '0;
      len_q    <= '0;
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      wr_state <= W_SKIP;
      word_cnt <= '0;
      mir_q    <= Mirror_Position;
      end_q    <= End_Position;
      len_q    <= len_in;
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      unique case (wr_state)
        W_SKIP: begin
          word_cnt <= word_cnt + 16'd1;
          if (mir_q >= end_q)  wr_state <= W_IDLE;
          else if (cap_word)   wr_state <= last_word ? W_IDLE : W_CAPTURE;
        end
        W_CAPTURE: begin
          word_cnt <= word_cnt + 16'd1;
          if (last_word) wr_state <= W_IDLE;
        end
        default: ;
      endcase
      if (we) wr_ptr <= wr_ptr + 1'b1;
      if (cap_word && !room) overflow <= 1'b1;
    end
  end

  // Read sequencer -> RAM/lane stage (B) -> output register (C); each stage
  // holds while the one after it is full and stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state   <= R_IDLE;
      rd_samp    <= '0;
      frame_cnt  <= '0;
      bin_q      <= '0;
      valid_b    <= 1'b0;
      pad_b      <= 1'b0;
      sof_b      <= 1'b0;
      eof_b      <= 1'b0;
      lane_b     <= '0;
      bin_b      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      sof        <= 1'b0;
      eof        <= 1'b0;
      bin_index  <= '0;
    end else begin
      if (accept) begin
        rd_state  <= (len_in == '0) ? R_IDLE : R_WAITBIN;
        rd_samp   <= '0;
        frame_cnt <= '0;
        bin_q     <= '0;
      end else begin
        unique case (rd_state)
          R_WAITBIN: begin
            if (written_nxt >= need)       rd_state <= R_DATA;
            else if (wr_state == W_IDLE)   rd_state <= R_IDLE;
          end
          R_DATA: begin
            if (issue) begin
              rd_samp <= rd_samp + 32'd1;
              if (frame_cnt == len_m1) begin
                if (len_q == NFFT_F) begin
                  frame_cnt <= '0;
                  bin_q     <= bin_q + 8'd1;
                  rd_state  <= R_WAITBIN;
                end else begin
                  frame_cnt <= frame_cnt + FW'(1);
                  rd_state  <= R_PAD;
                end
              end else begin
                frame_cnt <= frame_cnt + FW'(1);
              end
            end
          end
          R_PAD: begin
            if (issue) begin
              if (frame_cnt == LAST_F) begin
                frame_cnt <= '0;
                bin_q     <= bin_q + 8'd1;
                rd_state  <= R_WAITBIN;
              end else begin
                frame_cnt <= frame_cnt + FW'(1);
              end
            end
          end
          default: ;
        endcase
      end

      if (ready_b) begin
        valid_b <= issue;
        pad_b   <= (rd_state == R_PAD);
        sof_b   <= (frame_cnt == '0);
        eof_b   <= (frame_cnt == LAST_F);
        lane_b  <= lane_nxt;
        bin_b   <= bin_q;
      end

      if (advance_c) begin
        data_valid <= valid_b;
        if (valid_b) begin
          data_out  <= pad_b ? '0 : lane_word;
          sof       <= sof_b;
          eof       <= eof_b;
          bin_index <= bin_b;
        end else begin
          data_out <= '0;
          sof      <= 1'b0;
          eof      <= 1'b0;
        end
      end
      if (accept) bin_index <= '0;
    end
  end

endmodule

// File: tb/tb_rangebin_zeropad_buffer.sv
// Directed bench for rangebin_zeropad_buffer: ramp input, frame layout,
// stalls, overflow, clamping, empty windows and mid-run reset.
module tb_rangebin_zeropad_buffer;

  localparam int CYCLE_LIMIT = 20000;

  typedef struct packed {
    logic [13:0] d;
    logic        s;
    logic        e;
    logic [7:0]  b;
  } samp_t;

  logic        clk;
  logic        rst;
  logic [27:0] data_in;
  logic        start;
  logic [15:0] nPointsPerBin;
  logic [15:0] Mirror_Position;
  logic [15:0] End_Position;
  logic        out_ready;
  logic [13:0] data_out;
  logic        data_valid;
  logic        sof;
  logic        eof;
  logic [7:0]  bin_index;
  logic        busy;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  samp_t obs_q[$];
  samp_t ref_q[$];
  int    first_valid, last_eof, end_cycle, stall_viol;
  bit    busy_at_eof, timed_out;

  rangebin_zeropad_buffer #(
    .BIT_WIDTH(14),
    .LANES(2),
    .NFFT(1024),
    .DEPTH(4096)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .start(start),
    .nPointsPerBin(nPointsPerBin),
    .Mirror_Position(Mirror_Position),
    .End_Position(End_Position),
    .out_ready(out_ready),
    .data_out(data_out),
    .data_valid(data_valid),
    .sof(sof),
    .eof(eof),
    .bin_index(bin_index),
    .busy(busy),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference frame model: word k carries samples 2k (lane 0) and 2k+1, so
  // captured sample j of a window opened at mir is 2*mir + j.
  function automatic int stream_errors(input int mir, input int len, output int first_bad);
    int    errs;
    int    f;
    int    i;
    samp_t e;
    errs = 0;
    first_bad = -1;
    for (int n = 0; n < obs_q.size(); n++) begin
      f   = n / 1024;
      i   = n % 1024;
      e.d = (i < len) ? 14'(2 * mir + f * len + i) : 14'd0;
      e.s = (i == 0);
      e.e = (i == 1023);
      e.b = 8'(f);
      if (obs_q[n] !== e) begin
        errs++;
        if (first_bad < 0) first_bad = n;
      end
    end
    return errs;
  endfunction

  task automatic run_acq(input logic [15:0] mir, input logic [15:0] endp,
                         input logic [15:0] npts, input bit stall, input int restart_at);
    logic [13:0] pd;
    logic        ps, pe, prev_stall;
    logic [7:0]  pb;
    samp_t       s;
    obs_q.delete();
    first_valid = -1; last_eof = -1; end_cycle = -1; stall_viol = 0;
    busy_at_eof = 1'b0; timed_out = 1'b0; prev_stall = 1'b0;
    pd = '0; ps = 1'b0; pe = 1'b0; pb = '0;
    @(negedge clk);
    Mirror_Position = mir; End_Position = endp; nPointsPerBin = npts;
    start = 1'b1; out_ready = 1'b1; data_in = '0;
    @(negedge clk);
    start = 1'b0;
    // Garbage on the parameter pins proves they were latched at start.
    Mirror_Position = 16'd3; End_Position = 16'd7; nPointsPerBin = 16'd1;
    for (int c = 0; c < CYCLE_LIMIT; c++) begin
      if (c > 0) @(negedge clk);
      data_in   = {14'(2 * c + 1), 14'(2 * c)};
      start     = (c == restart_at);
      out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      if (prev_stall && !(data_valid && data_out === pd && sof === ps && eof === pe && bin_index === pb))
        stall_viol++;
      if (data_valid && first_valid < 0) first_valid = c;
      if (data_valid && out_ready) begin
        s = '{d: data_out, s: sof, e: eof, b: bin_index};
        obs_q.push_back(s);
        if (eof) begin
          last_eof    = c;
          busy_at_eof = busy;
        end
      end
      prev_stall = data_valid && !out_ready;
      pd = data_out; ps = sof; pe = eof; pb = bin_index;
      if (!busy) begin
        end_cycle = c;
        break;
      end
    end
    if (end_cycle < 0) timed_out = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; data_in = '0; out_ready = 1'b1;
    nPointsPerBin = '0; Mirror_Position = '0; End_Position = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({data_out, data_valid, sof, eof, bin_index, busy, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0",
               {data_out, data_valid, sof, eof, bin_index, busy, overflow});
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_nominal;
    int errs, fb;
    run_acq(16'd10, 16'd510, 16'd250, 1'b0, -1);
    checks++;
    if (timed_out !== 1'b0) begin errors++; $display("FAIL nominal_timeout: busy never dropped, required drop"); end
    checks++;
    if (obs_q.size() !== 4096) begin errors++; $display("FAIL nominal_count: got %0d samples, required 4096", obs_q.size()); end
    errs = stream_errors(10, 250, fb);
    checks++;
    if (errs !== 0) begin errors++; $display("FAIL nominal_stream: %0d bad samples (first %0d), required 0", errs, fb); end
    checks++;
    if (first_valid < 135 || first_valid > 137) begin
      errors++; $display("FAIL nominal_latency: first valid at cycle %0d, required 135..137", first_valid);
    end
    checks++;
    if (!(busy_at_eof && end_cycle > last_eof && end_cycle <= last_eof + 3)) begin
      errors++; $display("FAIL nominal_busy: busy@eof=%0d eof=%0d drop=%0d, required drop just after eof",
                         busy_at_eof, last_eof, end_cycle);
    end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL nominal_overflow: got %0d, required 0", overflow); end
    ref_q = obs_q;
  endtask

  task automatic test_partial;
    int errs, fb;
    run_acq(16'd10, 16'd510, 16'd300, 1'b0, -1);
    checks++;
    if (obs_q.size() !== 3072) begin errors++; $display("FAIL partial_count: got %0d samples, required 3072", obs_q.size()); end
    errs = stream_errors(10, 300, fb);
    checks++;
    if (errs !== 0) begin errors++; $display("FAIL partial_stream: %0d bad samples (first %0d), required 0", errs, fb); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL partial_overflow: got %0d, required 0", overflow); end
  endtask

  task automatic test_stall;
    int diffs;
    run_acq(16'd10, 16'd510, 16'd250, 1'b1, -1);
    checks++;
    if (timed_out !== 1'b0) begin errors++; $display("FAIL stall_timeout: busy never dropped, required drop"); end
    checks++;
    if (obs_q.size() !== ref_q.size()) begin
      errors++; $display("FAIL stall_count: got %0d samples, required %0d", obs_q.size(), ref_q.size());
    end
    diffs = 0;
    for (int n = 0; n < obs_q.size() && n < ref_q.size(); n++)
      if (obs_q[n] !== ref_q[n]) diffs++;
    checks++;
    if (diffs !== 0) begin errors++; $display("FAIL stall_stream: %0d samples differ from unstalled run, required 0", diffs); end
    checks++;
    if (stall_viol !== 0) begin errors++; $display("FAIL stall_hold: %0d unstable stall cycles, required 0", stall_viol); end
  endtask

  task automatic test_overflow;
    int errs, fb;
    run_acq(16'd0, 16'd3000, 16'd1024, 1'b0, -1);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_flag: got %0d, required 1", overflow); end
    checks++;
    if (obs_q.size() !== 4096) begin errors++; $display("FAIL overflow_count: got %0d samples, required 4096", obs_q.size()); end
    errs = stream_errors(0, 1024, fb);
    checks++;
    if (errs !== 0) begin errors++; $display("FAIL overflow_stream: %0d bad samples (first %0d), required 0", errs, fb); end
  endtask

  task automatic test_clamp;
    int errs, fb;
    run_acq(16'd0, 16'd1100, 16'd2000, 1'b0, -1);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL clamp_overflow_cleared: got %0d, required 0", overflow); end
    checks++;
    if (obs_q.size() !== 2048) begin errors++; $display("FAIL clamp_count: got %0d samples, required 2048", obs_q.size()); end
    errs = stream_errors(0, 1024, fb);
    checks++;
    if (errs !== 0) begin errors++; $display("FAIL clamp_stream: %0d bad samples (first %0d), required 0", errs, fb); end
  endtask

  task automatic test_zero_len;
    run_acq(16'd2, 16'd20, 16'd0, 1'b0, -1);
    checks++;
    if (obs_q.size() !== 0) begin errors++; $display("FAIL zero_len_count: got %0d samples, required 0", obs_q.size()); end
    checks++;
    if (end_cycle < 20 || end_cycle > 22) begin
      errors++; $display("FAIL zero_len_busy: busy dropped at cycle %0d, required 20..22", end_cycle);
    end
  endtask

  task automatic test_empty_window;
    run_acq(16'd50, 16'd50, 16'd10, 1'b0, -1);
    checks++;
    if (obs_q.size() !== 0) begin errors++; $display("FAIL empty_window_count: got %0d samples, required 0", obs_q.size()); end
    checks++;
    if (end_cycle < 0 || end_cycle > 4) begin
      errors++; $display("FAIL empty_window_busy: busy dropped at cycle %0d, required 0..4", end_cycle);
    end
  endtask

  task automatic test_start_ignored;
    int errs, fb;
    run_acq(16'd10, 16'd510, 16'd250, 1'b0, 300);
    checks++;
    if (obs_q.size() !== 4096) begin errors++; $display("FAIL start_ignored_count: got %0d samples, required 4096", obs_q.size()); end
    errs = stream_errors(10, 250, fb);
    checks++;
    if (errs !== 0) begin errors++; $display("FAIL start_ignored_stream: %0d bad samples (first %0d), required 0", errs, fb); end
  endtask

  task automatic test_reset_midrun;
    int  bin1_seen, errs, fb;
    bit  reached;
    reached = 1'b0; bin1_seen = 0;
    @(negedge clk);
    Mirror_Position = 16'd10; End_Position = 16'd510; nPointsPerBin = 16'd250;
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) @(negedge clk);
      data_in = {14'(2 * c + 1), 14'(2 * c)};
      #1;
      if (data_valid && bin_index == 8'd1 && !sof) bin1_seen++;
      if (bin1_seen >= 20) begin reached = 1'b1; break; end
    end
    checks++;
    if (reached !== 1'b1) begin errors++; $display("FAIL midrun_reach_bin1: bin 1 data not seen, required seen"); end
    rst = 1'b0;
    #1;
    checks++;
    if ({data_out, data_valid, sof, eof, bin_index, busy, overflow} !== '0) begin
      errors++; $display("FAIL midrun_reset_immediate: got %h, required 0",
                         {data_out, data_valid, sof, eof, bin_index, busy, overflow});
    end
    @(posedge clk); #1;
    checks++;
    if ({data_out, data_valid, sof, eof, bin_index, busy, overflow} !== '0) begin
      errors++; $display("FAIL midrun_reset_held: got %h, required 0",
                         {data_out, data_valid, sof, eof, bin_index, busy, overflow});
    end
    @(negedge clk);
    rst = 1'b1;
    run_acq(16'd10, 16'd510, 16'd250, 1'b0, -1);
    checks++;
    if (obs_q.size() !== 4096) begin errors++; $display("FAIL midrun_restart_count: got %0d samples, required 4096", obs_q.size()); end
    errs = stream_errors(10, 250, fb);
    checks++;
    if (errs !== 0) begin errors++; $display("FAIL midrun_restart_stream: %0d bad samples (first %0d), required 0", errs, fb); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_partial();
    test_stall();
    test_overflow();
    test_clamp();
    test_zero_len();
    test_empty_window();
    test_start_ignored();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rangebin_zeropad_buffer.md
RANGEBIN_ZEROPAD_BUFFER -- requirements
Module: rangebin_zeropad_buffer

Interface
REQ-001 Parameter BIT_WIDTH, default 14, sample width in bits.
REQ-002 Parameter LANES, default 2, samples per input word; legal 1, 2, 4.
REQ-003 Parameter NFFT, default 1024, output frame length in samples; power of 2.
REQ-004 Parameter DEPTH, default 4096, buffer capacity in samples; multiple of LANES.
REQ-005 clk  in  1  single clock; every register is clocked on its rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 data_in  in  BIT_WIDTH*LANES  packed samples; lane 0 occupies the LSBs and is the earliest sample.
REQ-008 start  in  1  one-cycle pulse that opens an acquisition.
REQ-009 nPointsPerBin  in  16  samples per range bin.
REQ-010 Mirror_Position  in  16  input-word count after start at which capture begins.
REQ-011 End_Position  in  16  input-word count after start at which capture ends (exclusive).
REQ-012 out_ready  in  1  downstream accepts data_out.
REQ-013 data_out  out  BIT_WIDTH  serial sample, or zero during padding.
REQ-014 data_valid  out  1  data_out holds a valid sample.
REQ-015 sof / eof  out  1 each  first / last sample of an NFFT frame; qualified by data_valid.
REQ-016 bin_index  out  8  index of the current range bin; 0 for the first frame.
REQ-017 busy  out  1  acquisition or readout in progress.
REQ-018 overflow  out  1  sticky flag: capture data was dropped.

Function
REQ-019 All parameter inputs shall be latched on an accepted start; a start asserted while busy=1 shall be ignored.
REQ-020 Write FSM states: IDLE -> SKIP on start -> CAPTURE when word count = Mirror_Position -> IDLE when word count = End_Position; if Mirror_Position >= End_Position, SKIP shall return to IDLE and capture no words.
REQ-021 The word counter shall be 0 on the cycle after start and increment by 1 per cycle; the word present at count k shall be written when Mirror_Position <= k < End_Position.
REQ-022 The buffer shall be internal dual-port RAM, LANES samples wide, with a write pointer that does not wrap; a word that would exceed DEPTH samples shall be dropped and shall set overflow.
REQ-023 The effective bin length L shall be min(nPointsPerBin, NFFT); if L = 0, no frames shall be produced and busy shall drop when capture ends.
REQ-024 Read FSM states: IDLE -> WAITBIN -> DATA -> PAD -> (WAITBIN | IDLE).
REQ-025 WAITBIN -> DATA when at least (bin_index+1)*L samples have been written; WAITBIN -> IDLE when capture has ended and fewer samples remain, discarding the partial bin.
REQ-026 In DATA, L buffered samples shall be emitted in capture order, lane 0 before lane 1 within a word; in PAD, NFFT-L zero samples shall be emitted, and PAD shall be skipped when L = NFFT.
REQ-027 Each frame shall be exactly NFFT samples; sof shall mark sample 0 and eof sample NFFT-1; bin_index shall increment after eof.
REQ-028 Output handshake: a sample transfers when data_valid & out_ready; while data_valid=1 and out_ready=0, data_out, sof, eof and bin_index shall be held stable.
REQ-029 data_valid shall never assert in IDLE or WAITBIN; it may deassert only between transfers.
REQ-030 Latency: with out_ready=1, the first data_valid of bin 0 shall assert within 3 cycles of the write that completes L samples.
REQ-031 Readout of bin n shall overlap capture of later bins; a bin's samples shall be read only after they have been written.
REQ-032 busy shall be 1 from the cycle after an accepted start until both FSMs are in IDLE.
REQ-033 Simultaneous RAM read and write to different addresses shall be legal; a same-address conflict is impossible by REQ-031.
REQ-034 overflow shall clear only on reset or an accepted start.

Reset
REQ-035 While rst=0: both FSMs shall be in IDLE, all counters and pointers 0, and data_out, data_valid, sof, eof, bin_index, busy and overflow 0.
REQ-036 Reset asserted mid-operation shall abort immediately; after release, the block shall accept a new start with no residual data.

Verification
REQ-037 Mirror=10, End=510, nPointsPerBin=250, LANES=2, ramp input, out_ready=1 -> 4 frames, each 250 ramp samples then 774 zeros; bin_index 0..3; busy drops after the last eof.
REQ-038 nPointsPerBin=300, 500 words captured -> 3 frames, remaining 100 samples discarded, no overflow.
REQ-039 Random out_ready stalls -> the transferred sample stream is identical to the out_ready=1 case; outputs stay stable during stalls.
REQ-040 Mirror=0, End=3000, DEPTH=4096 -> overflow=1 and exactly 4096 samples stored; frames use only stored data.
REQ-041 nPointsPerBin=2000 -> L clamped to 1024; no PAD samples; sof and eof are 1023 samples apart.
REQ-042 Reset pulsed during DATA of bin 1, then a new start -> all outputs 0 during reset; the new acquisition's bin_index starts at 0.
